// File: rtl/pcs_drp_arbiter.sv
// DRP port arbiter between the PCS core (level request/grant, pass-through)
// and a single-outstanding management transaction engine with timeout.
module pcs_drp_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_drp_req,
    output logic        core_drp_gnt,
    input  logic        core_den,
    input  logic        core_dwe,
    input  logic [15:0] core_daddr,
    input  logic [15:0] core_di,
    output logic        core_drdy,
    output logic [15:0] core_drpdo,
    input  logic        mgmt_req,
    input  logic        mgmt_we,
    input  logic [15:0] mgmt_addr,
    input  logic [15:0] mgmt_wdata,
    output logic        mgmt_busy,
    output logic        mgmt_done,
    output logic        mgmt_err,
    output logic [15:0] mgmt_rdata,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_daddr,
    output logic [15:0] drp_di,
    input  logic        drp_drdy,
    input  logic [15:0] drp_drpdo
);

    typedef enum logic [1:0] {StIdle, StCoreGnt, StMgmtIssue, StMgmtWait} state_e;

    // Last wait-cycle index: TIMEOUT wait cycles in total before abort.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        last_mgmt_q, last_mgmt_d;  // 1: mgmt was served most recently
    logic        busy_q, busy_d;            // mgmt transaction pending or in flight
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        out_q, out_d;              // core transaction outstanding
    logic [15:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;

    // Next-state, capture and DRP port muxing.
    always_comb begin
        state_d      = state_q;
        last_mgmt_d  = last_mgmt_q;
        busy_d       = busy_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        out_d        = out_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        rdata_d      = 16'h0000;
        core_drp_gnt = 1'b0;
        core_drdy    = 1'b0;
        core_drpdo   = 16'h0000;
        drp_den      = 1'b0;
        drp_dwe      = 1'b0;
        drp_daddr    = 16'h0000;
        drp_di       = 16'h0000;

        // A request while busy is dropped; capture only when free.
        if (mgmt_req && !busy_q) begin
            busy_d  = 1'b1;
            we_d    = mgmt_we;
            addr_d  = mgmt_addr;
            wdata_d = mgmt_wdata;
        end

        unique case (state_q)
            StIdle: begin
                // On a tie the side not served last wins.
                if (core_drp_req && (!busy_q || last_mgmt_q)) begin
                    state_d     = StCoreGnt;
                    last_mgmt_d = 1'b0;
                    out_d       = 1'b0;
                end else if (busy_q) begin
                    state_d     = StMgmtIssue;
                    last_mgmt_d = 1'b1;
                end
            end
            StCoreGnt: begin
                core_drp_gnt = 1'b1;
                drp_den      = core_den;
                drp_dwe      = core_dwe;
                drp_daddr    = core_daddr;
                drp_di       = core_di;
                core_drdy    = drp_drdy;
                core_drpdo   = drp_drpdo;
                out_d        = core_den | (out_q & ~drp_drdy);
                // Release only once the last core access has completed.
                if (!core_drp_req && !out_d) begin
                    state_d = StIdle;
                end
            end
            StMgmtIssue: begin
                drp_den   = 1'b1;
                drp_dwe   = we_q;
                drp_daddr = addr_q;
                drp_di    = we_q ? wdata_q : 16'h0000;
                cnt_d     = 16'h0000;
                state_d   = StMgmtWait;
            end
            StMgmtWait: begin
                // drdy wins over timeout when both land in the same cycle.
                if (drp_drdy) begin
                    done_d  = 1'b1;
                    rdata_d = we_q ? 16'h0000 : drp_drpdo;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset overrides every same-cycle input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_mgmt_q <= 1'b1;
            busy_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            out_q       <= 1'b0;
            cnt_q       <= 16'h0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            last_mgmt_q <= last_mgmt_d;
            busy_q      <= busy_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mgmt_busy  = busy_q;
    assign mgmt_done  = done_q;
    assign mgmt_err   = err_q;
    assign mgmt_rdata = rdata_q;

endmodule

// File: tb/tb_pcs_drp_arbiter.sv
// Scoreboard bench for pcs_drp_arbiter: directed stimulus pushes expected
// mgmt/core completions; a monitor pops and compares them as they appear.
module tb_pcs_drp_arbiter;

    localparam int unsigned TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_drp_req, core_drp_gnt, core_den, core_dwe, core_drdy;
    logic [15:0] core_daddr, core_di, core_drpdo;
    logic        mgmt_req, mgmt_we, mgmt_busy, mgmt_done, mgmt_err;
    logic [15:0] mgmt_addr, mgmt_wdata, mgmt_rdata;
    logic        drp_den, drp_dwe, drp_drdy;
    logic [15:0] drp_daddr, drp_di, drp_drpdo;

    always #5 clk = ~clk;

    pcs_drp_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_drp_req (core_drp_req),
        .core_drp_gnt (core_drp_gnt),
        .core_den     (core_den),
        .core_dwe     (core_dwe),
        .core_daddr   (core_daddr),
        .core_di      (core_di),
        .core_drdy    (core_drdy),
        .core_drpdo   (core_drpdo),
        .mgmt_req     (mgmt_req),
        .mgmt_we      (mgmt_we),
        .mgmt_addr    (mgmt_addr),
        .mgmt_wdata   (mgmt_wdata),
        .mgmt_busy    (mgmt_busy),
        .mgmt_done    (mgmt_done),
        .mgmt_err     (mgmt_err),
        .mgmt_rdata   (mgmt_rdata),
        .drp_den      (drp_den),
        .drp_dwe      (drp_dwe),
        .drp_daddr    (drp_daddr),
        .drp_di       (drp_di),
        .drp_drdy     (drp_drdy),
        .drp_drpdo    (drp_drpdo)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } mexp_t;

    mexp_t       mq[$];
    logic [15:0] cq[$];
    int          n_checks = 0;
    int          n_pass = 0;

    // DRP model knobs: latency after den (0 = never answers), data, extra stray drdy cycle.
    int          model_lat = 3;
    logic [15:0] model_data = 16'h0000;
    int          resp_cyc = -1;
    int          extra_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_m(input logic [15:0] rdata, input logic err);
        mexp_t e;
        e.rdata = rdata;
        e.err   = err;
        mq.push_back(e);
    endtask

    // Check {gnt, busy, den} and drp_daddr this cycle, then advance one cycle.
    task automatic nxt(input string name, input logic [2:0] exp, input logic [15:0] exp_addr);
        @(negedge clk);
        chk(name, 64'({core_drp_gnt, mgmt_busy, drp_den, drp_daddr}), 64'({exp, exp_addr}));
        step();
    endtask

    task automatic quiet(input int n, output int events);
        events = 0;
        repeat (n) begin
            @(negedge clk);
            if (drp_den || mgmt_done || core_drdy || mgmt_busy) events++;
            step();
        end
    endtask

    task automatic mgmt_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic dup, output int lat, output int dens,
                            output logic [15:0] den_addr, output logic [15:0] den_di,
                            output logic den_dwe, output logic busy_at_done);
        int   start;
        logic seen;
        start      = cyc;
        mgmt_req   = 1'b1;
        mgmt_we    = we;
        mgmt_addr  = addr;
        mgmt_wdata = wdata;
        step();
        if (dup) begin
            mgmt_we   = 1'b0;
            mgmt_addr = 16'h0077;
        end else begin
            mgmt_req = 1'b0;
        end
        lat = -1; dens = 0; den_addr = '0; den_di = '0; den_dwe = 1'b0;
        busy_at_done = 1'b1; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (drp_den) begin
                dens++;
                den_addr = drp_daddr;
                den_di   = drp_di;
                den_dwe  = drp_dwe;
            end
            if (mgmt_done) begin
                seen         = 1'b1;
                lat          = cyc - start;
                busy_at_done = mgmt_busy;
            end
            step();
            mgmt_req = 1'b0;
        end
    endtask

    // DRP transceiver model: den seen in cycle D answers in cycle D+model_lat.
    initial begin
        drp_drdy  = 1'b0;
        drp_drpdo = 16'h0000;
        forever begin
            @(negedge clk);
            if (drp_den && model_lat > 0) resp_cyc = cyc + model_lat;
            @(posedge clk);
            #1;
            drp_drdy  = (cyc == resp_cyc) || (cyc == extra_cyc);
            drp_drpdo = drp_drdy ? model_data : 16'h0000;
        end
    end

    // Monitor: pop expectations whenever the DUT reports a completion.
    initial begin : monitor
        logic        prev_done;
        mexp_t       e;
        logic [15:0] c;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mgmt_done) begin
                chk("mgmt_done_spacing", 64'(prev_done), 64'd0);
                chk("mgmt_done_expected", 64'(mq.size() != 0), 64'd1);
                if (mq.size() != 0) begin
                    e = mq.pop_front();
                    chk("mgmt_rdata", 64'(mgmt_rdata), 64'(e.rdata));
                    chk("mgmt_err", 64'(mgmt_err), 64'(e.err));
                end
            end
            if (core_drdy) begin
                chk("core_drdy_expected", 64'(cq.size() != 0), 64'd1);
                if (cq.size() != 0) begin
                    c = cq.pop_front();
                    chk("core_drpdo", 64'(core_drpdo), 64'(c));
                end
            end
            prev_done = mgmt_done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, dens, ev;
        logic [15:0] a, di;
        logic        dwe, bsy;

        rst = 1'b1; core_drp_req = 1'b0; core_den = 1'b0; core_dwe = 1'b0;
        core_daddr = 16'h0; core_di = 16'h0; mgmt_req = 1'b0; mgmt_we = 1'b0;
        mgmt_addr = 16'h0; mgmt_wdata = 16'h0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_ctl", 64'({core_drp_gnt, core_drdy, mgmt_busy, mgmt_done, mgmt_err,
                              drp_den, drp_dwe}), 64'd0);
        chk("reset_data", {core_drpdo, mgmt_rdata, drp_daddr, drp_di}, 64'd0);
        step();
        rst = 1'b0;
        step();

        // Mgmt read, drdy 3 cycles after den.
        model_lat = 3; model_data = 16'h1234; push_m(16'h1234, 1'b0);
        mgmt_txn(1'b0, 16'h0051, 16'hDEAD, 1'b0, lat, dens, a, di, dwe, bsy);
        chk("rd_latency", 64'(lat), 64'd6);
        chk("rd_den_pulses", 64'(dens), 64'd1);
        chk("rd_addr", 64'(a), 64'h51);
        chk("rd_dwe_di", 64'({dwe, di}), 64'd0);
        chk("rd_busy_at_done", 64'(bsy), 64'd0);

        // Mgmt write with a second request while busy (must be dropped).
        model_data = 16'h5555; push_m(16'h0000, 1'b0);
        mgmt_txn(1'b1, 16'h000A, 16'hBEEF, 1'b1, lat, dens, a, di, dwe, bsy);
        chk("wr_latency", 64'(lat), 64'd6);
        chk("wr_den_pulses", 64'(dens), 64'd1);
        chk("wr_addr", 64'(a), 64'h0A);
        chk("wr_dwe_di", 64'({dwe, di}), 64'h1BEEF);
        quiet(12, ev);
        chk("busy_req_dropped", 64'(ev), 64'd0);

        // Core: two reads, request dropped while the second is outstanding.
        model_lat = 2; model_data = 16'hC0DE;
        core_drp_req = 1'b1;
        nxt("core_gnt_latency", 3'b000, 16'h0000);
        core_den = 1'b1; core_daddr = 16'h0010; cq.push_back(16'hC0DE);
        nxt("core_rd1", 3'b101, 16'h0010);
        core_den = 1'b0; core_daddr = 16'h0000;
        nxt("core_rd1_wait", 3'b100, 16'h0000);
        nxt("core_rd1_drdy", 3'b100, 16'h0000);
        model_data = 16'hABCD; core_den = 1'b1; core_daddr = 16'h0020; cq.push_back(16'hABCD);
        nxt("core_rd2", 3'b101, 16'h0020);
        core_den = 1'b0; core_daddr = 16'h0000; core_drp_req = 1'b0;
        nxt("core_hold_outstanding", 3'b100, 16'h0000);
        nxt("core_hold_drdy_cycle", 3'b100, 16'h0000);
        nxt("core_released", 3'b000, 16'h0000);

        // Collision after reset: core first, then alternate.
        rst = 1'b1; step(); step(); rst = 1'b0;
        model_lat = 3; model_data = 16'h3333;
        core_drp_req = 1'b1; mgmt_req = 1'b1; mgmt_we = 1'b0; mgmt_addr = 16'h0033;
        push_m(16'h3333, 1'b0);
        nxt("col_req", 3'b000, 16'h0000);
        mgmt_req = 1'b0;
        nxt("col_core_first", 3'b110, 16'h0000);
        nxt("col_core_hold", 3'b110, 16'h0000);
        core_drp_req = 1'b0;
        nxt("col_core_release", 3'b110, 16'h0000);
        core_drp_req = 1'b1;
        nxt("col_idle_tie", 3'b010, 16'h0000);
        nxt("col_mgmt_issue", 3'b011, 16'h0033);
        repeat (3) nxt("col_mgmt_wait", 3'b010, 16'h0000);
        mgmt_req = 1'b1; mgmt_addr = 16'h0044; push_m(16'h4444, 1'b0);
        nxt("col_done_accept", 3'b000, 16'h0000);
        mgmt_req = 1'b0;
        nxt("col_core_again", 3'b110, 16'h0000);
        core_drp_req = 1'b0;
        nxt("col_core_release2", 3'b110, 16'h0000);
        core_drp_req = 1'b1; model_data = 16'h4444;
        nxt("col_idle_tie2", 3'b010, 16'h0000);
        nxt("col_mgmt_issue2", 3'b011, 16'h0044);
        repeat (3) nxt("col_mgmt_wait2", 3'b010, 16'h0000);
        nxt("col_done2", 3'b000, 16'h0000);
        core_drp_req = 1'b0;
        nxt("col_core_final", 3'b100, 16'h0000);
        nxt("col_all_idle", 3'b000, 16'h0000);

        // Timeout with no response, then a late drdy in IDLE.
        model_lat = 0; push_m(16'h0000, 1'b1);
        mgmt_txn(1'b0, 16'h0099, 16'h0000, 1'b0, lat, dens, a, di, dwe, bsy);
        chk("to_latency", 64'(lat), 64'd11);
        chk("to_den_pulses", 64'(dens), 64'd1);
        model_data = 16'h7777; extra_cyc = cyc + 1;
        quiet(6, ev);
        chk("late_drdy_ignored", 64'(ev), 64'd0);

        // drdy on the last wait cycle succeeds; one cycle later is a timeout.
        model_lat = 8; model_data = 16'h8888; push_m(16'h8888, 1'b0);
        mgmt_txn(1'b0, 16'h00A0, 16'h0000, 1'b0, lat, dens, a, di, dwe, bsy);
        chk("edge_ok_latency", 64'(lat), 64'd11);
        model_lat = 9; push_m(16'h0000, 1'b1);
        mgmt_txn(1'b0, 16'h00A1, 16'h0000, 1'b0, lat, dens, a, di, dwe, bsy);
        chk("edge_to_latency", 64'(lat), 64'd11);
        quiet(4, ev);
        chk("edge_to_quiet", 64'(ev), 64'd0);

        // Reset in MGMT_WAIT with conflicting inputs: no done pulse afterwards.
        model_lat = 0;
        mgmt_req = 1'b1; mgmt_we = 1'b0; mgmt_addr = 16'h0066;
        nxt("rst_req", 3'b000, 16'h0000);
        mgmt_req = 1'b0;
        nxt("rst_pending", 3'b010, 16'h0000);
        nxt("rst_issue", 3'b011, 16'h0066);
        nxt("rst_wait", 3'b010, 16'h0000);
        rst = 1'b1; mgmt_req = 1'b1; core_drp_req = 1'b1; core_den = 1'b1;
        nxt("rst_assert_cycle", 3'b010, 16'h0000);
        @(negedge clk);
        chk("rst_mid_ctl", 64'({core_drp_gnt, core_drdy, mgmt_busy, mgmt_done, mgmt_err,
                                drp_den, drp_dwe}), 64'd0);
        chk("rst_mid_data", {core_drpdo, mgmt_rdata, drp_daddr, drp_di}, 64'd0);
        step();
        rst = 1'b0; mgmt_req = 1'b0; core_drp_req = 1'b0; core_den = 1'b0;
        quiet(12, ev);
        chk("rst_no_done", 64'(ev), 64'd0);

        chk("mgmt_queue_drained", 64'(mq.size()), 64'd0);
        chk("core_queue_drained", 64'(cq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
